// File: rtl/cache_tg_pkg.sv
// Shared field layout, FSM state type and pack/unpack helpers for the cache traffic generator.
package cache_tg_pkg;

  localparam int REQ_W            = 70;
  localparam int RSP_W            = 52;
  localparam int DATA_W           = 32;
  localparam int ADDR_W           = 32;
  localparam int BE_W             = 4;
  localparam int ADDR_LO_W        = 16;
  localparam int REQ_IS_WRITE_BIT = 69;
  localparam int REQ_RSVD_BIT     = 68;
  localparam int REQ_BE_LSB       = 64;
  localparam int REQ_ADDR_LSB     = 32;
  localparam int REQ_DATA_LSB     = 0;
  localparam int RSP_BE_LSB       = 48;
  localparam int RSP_ADDR_LSB     = 32;
  localparam int RSP_DATA_LSB     = 0;

  localparam logic [31:0]     LFSR_POLY = 32'h8020_0003;
  localparam logic [BE_W-1:0] FULL_BE   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DRAIN_W,
    ST_READ,
    ST_DRAIN_R,
    ST_DONE
  } tg_state_e;

  typedef struct packed {
    logic [BE_W-1:0]      byte_en;
    logic [ADDR_LO_W-1:0] addr_lo;
    logic [DATA_W-1:0]    data;
  } rsp_t;

  function automatic logic [REQ_W-1:0] pack_request(
    input logic              is_write,
    input logic [BE_W-1:0]   byte_en,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [REQ_W-1:0] req;
    req                             = '0;
    req[REQ_IS_WRITE_BIT]           = is_write;
    req[REQ_RSVD_BIT]               = 1'b0;
    req[REQ_BE_LSB +: BE_W]         = byte_en;
    req[REQ_ADDR_LSB +: ADDR_W]     = addr;
    req[REQ_DATA_LSB +: DATA_W]     = data;
    return req;
  endfunction

  function automatic rsp_t unpack_response(input logic [RSP_W-1:0] rsp);
    rsp_t r;
    r.byte_en = rsp[RSP_BE_LSB +: BE_W];
    r.addr_lo = rsp[RSP_ADDR_LSB +: ADDR_LO_W];
    r.data    = rsp[RSP_DATA_LSB +: DATA_W];
    return r;
  endfunction

  // Galois step: shift right, fold the polynomial back in when a one falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
  endfunction

endpackage

// File: rtl/cache_traffic_gen_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; exposes both the current and the next state.
module lfsr32
  import cache_tg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state,
  output logic [31:0] state_next
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (step) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state      = state_q;
  assign state_next = state_d;

endmodule

// File: rtl/cache_traffic_gen.sv
// Write-then-readback traffic generator for one cache get/put port, with in-order response checking.
module cache_traffic_gen
  import cache_tg_pkg::*;
#(
  parameter int unsigned NUM_REQS        = 64,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] SEED            = 32'h0000_ACE1,
  parameter int unsigned TIMEOUT         = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  output logic             put_valid,
  input  logic             put_ready,
  output logic [REQ_W-1:0] put_request,
  output logic             get_valid,
  input  logic             get_ready,
  input  logic [RSP_W-1:0] get_response,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [15:0]      err_count
);

  localparam logic [15:0] NREQ   = 16'(NUM_REQS);
  localparam logic [3:0]  MAXO   = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] TMO    = 32'(TIMEOUT);

  tg_state_e        state_q, state_d;
  logic [15:0]      issued_q, issued_d;
  logic [15:0]      rsp_idx_q, rsp_idx_d;
  logic [3:0]       outstanding_q, outstanding_d;
  logic [31:0]      stall_q, stall_d;
  logic [15:0]      err_q, err_d;
  logic             timeout_q, timeout_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             put_valid_q, put_valid_d;
  logic [REQ_W-1:0] put_request_q, put_request_d;
  logic             get_valid_q, get_valid_d;

  logic             put_fire, get_fire, get_ok;
  logic             active, rsp_is_read, rsp_bad, err_event;
  logic             gen_load, gen_step, chk_load, chk_step;
  logic [15:0]      exp_addr_lo;
  rsp_t             rsp;
  logic [31:0]      gen_state_unused, gen_next;
  logic [31:0]      chk_state, chk_next_unused;

  lfsr32 u_gen_lfsr (
    .clk        (CLK),
    .rst        (RST),
    .load       (gen_load),
    .step       (gen_step),
    .seed       (SEED),
    .state      (gen_state_unused),
    .state_next (gen_next)
  );

  lfsr32 u_chk_lfsr (
    .clk        (CLK),
    .rst        (RST),
    .load       (chk_load),
    .step       (chk_step),
    .seed       (SEED),
    .state      (chk_state),
    .state_next (chk_next_unused)
  );

  always_comb begin
    put_fire    = put_valid_q & put_ready;
    get_fire    = get_valid_q & get_ready;
    get_ok      = get_fire & (outstanding_q != 4'd0);
    active      = (state_q == ST_WRITE) || (state_q == ST_DRAIN_W) ||
                  (state_q == ST_READ)  || (state_q == ST_DRAIN_R);
    rsp_is_read = (state_q == ST_READ) || (state_q == ST_DRAIN_R);
    rsp         = unpack_response(get_response);
    exp_addr_lo = BASE_ADDR[15:0] + {rsp_idx_q[13:0], 2'b00};
    rsp_bad     = (rsp.addr_lo != exp_addr_lo) || (rsp.byte_en != FULL_BE) ||
                  (rsp_is_read && (rsp.data != chk_state));
    // A get with nothing outstanding is one error on its own and is not field-checked.
    err_event   = get_fire & (~get_ok | rsp_bad);

    state_d       = state_q;
    issued_d      = issued_q;
    rsp_idx_d     = rsp_idx_q;
    outstanding_d = outstanding_q;
    stall_d       = stall_q;
    err_d         = err_q;
    timeout_d     = timeout_q;
    gen_load      = 1'b0;
    chk_load      = 1'b0;
    gen_step      = put_fire & (state_q == ST_WRITE);
    chk_step      = get_ok & rsp_is_read;

    if (put_fire) issued_d = issued_q + 16'd1;
    if (get_ok) rsp_idx_d = rsp_idx_q + 16'd1;
    if (put_fire && !get_ok) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!put_fire && get_ok) begin
      outstanding_d = outstanding_q - 4'd1;
    end
    if (err_event && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    if (active) stall_d = (put_fire || get_fire) ? 32'd0 : stall_q + 32'd1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_WRITE;
          issued_d      = '0;
          rsp_idx_d     = '0;
          outstanding_d = '0;
          stall_d       = '0;
          err_d         = '0;
          timeout_d     = 1'b0;
          gen_load      = 1'b1;
          chk_load      = 1'b1;
        end
      end
      ST_WRITE: if (put_fire && (issued_q == NREQ - 16'd1)) state_d = ST_DRAIN_W;
      ST_DRAIN_W: begin
        if (outstanding_q == 4'd0) begin
          state_d   = ST_READ;
          issued_d  = '0;
          rsp_idx_d = '0;
        end
      end
      ST_READ:    if (put_fire && (issued_q == NREQ - 16'd1)) state_d = ST_DRAIN_R;
      ST_DRAIN_R: if (outstanding_d == 4'd0) state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase

    if (active && (stall_d >= TMO)) begin
      state_d   = ST_DONE;
      timeout_d = 1'b1;
    end

    // Registered outputs are derived from next-state values so they line up with the state.
    put_valid_d   = ((state_d == ST_WRITE) || (state_d == ST_READ)) &&
                    (issued_d < NREQ) && (outstanding_d < MAXO);
    put_request_d = put_valid_d ?
                    pack_request(state_d == ST_WRITE, FULL_BE,
                                 BASE_ADDR + {14'd0, issued_d, 2'b00},
                                 (state_d == ST_WRITE) ? gen_next : 32'd0) : '0;
    get_valid_d   = (state_d == ST_WRITE) || (state_d == ST_DRAIN_W) ||
                    (state_d == ST_READ)  || (state_d == ST_DRAIN_R);
    busy_d        = get_valid_d;
    done_d        = (state_d == ST_DONE);
    pass_d        = done_d && (err_d == 16'd0) && !timeout_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      issued_q      <= '0;
      rsp_idx_q     <= '0;
      outstanding_q <= '0;
      stall_q       <= '0;
      err_q         <= '0;
      timeout_q     <= 1'b0;
      pass_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      put_valid_q   <= 1'b0;
      put_request_q <= '0;
      get_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      rsp_idx_q     <= rsp_idx_d;
      outstanding_q <= outstanding_d;
      stall_q       <= stall_d;
      err_q         <= err_d;
      timeout_q     <= timeout_d;
      pass_q        <= pass_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      put_valid_q   <= put_valid_d;
      put_request_q <= put_request_d;
      get_valid_q   <= get_valid_d;
    end
  end

  assign put_valid   = put_valid_q;
  assign put_request = put_request_q;
  assign get_valid   = get_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Directed bench: runs cache_traffic_gen against a behavioural echo-memory cache in several responder modes.
module tb_cache_traffic_gen;

  localparam int NREQ = 4;
  localparam int MAXO = 4;
  localparam int TMO  = 64;

  localparam int MODE_IDEAL    = 0;
  localparam int MODE_CORRUPT  = 1;
  localparam int MODE_RANDOM   = 2;
  localparam int MODE_NOGET    = 3;
  localparam int MODE_SPURIOUS = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        put_valid;
  logic        put_ready = 1'b1;
  logic [69:0] put_request;
  logic        get_valid;
  logic        get_ready = 1'b0;
  logic [51:0] get_response = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;

  int testsRun    = 0;
  int testsFailed = 0;
  int mode        = MODE_IDEAL;

  logic [31:0] mem [0:15];
  logic [51:0] pendRsp[$];
  int          pendTime[$];
  bit          pendWr[$];
  int          cyc = 0;
  int          modelOut = 0;
  int          peakOut = 0;
  int          stabErr = 0;
  int          writesPopped = 0;
  bit          spurDone = 1'b0;
  bit          prevStall = 1'b0;
  logic [69:0] prevReq = '0;

  always #5 CLK = ~CLK;

  cache_traffic_gen #(
    .NUM_REQS        (NREQ),
    .BASE_ADDR       (32'h0000_1000),
    .MAX_OUTSTANDING (MAXO),
    .SEED            (32'h0000_ACE1),
    .TIMEOUT         (TMO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .put_valid    (put_valid),
    .put_ready    (put_ready),
    .put_request  (put_request),
    .get_valid    (get_valid),
    .get_ready    (get_ready),
    .get_response (get_response),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .err_count    (err_count)
  );

  // Behavioural cache: samples handshakes on the edge, then drives its outputs 1 time unit later.
  always @(posedge CLK) begin : responder
    logic [69:0] req;
    logic [31:0] rdata;
    int          idx;
    int          lat;
    cyc++;
    if (RST) begin
      pendRsp.delete();
      pendTime.delete();
      pendWr.delete();
      modelOut     = 0;
      peakOut      = 0;
      stabErr      = 0;
      writesPopped = 0;
      spurDone     = 1'b0;
      prevStall    = 1'b0;
    end else begin
      if (prevStall && (put_valid !== 1'b1 || put_request !== prevReq)) stabErr++;
      prevStall = (put_valid === 1'b1) && !put_ready;
      prevReq   = put_request;
      if (get_valid && get_ready && pendRsp.size() > 0) begin
        if (pendWr[0]) writesPopped++;
        void'(pendRsp.pop_front());
        void'(pendTime.pop_front());
        void'(pendWr.pop_front());
        modelOut--;
      end
      if (put_valid && put_ready) begin
        req = put_request;
        idx = int'((req[63:32] - 32'h0000_1000) >> 2) & 15;
        if (req[69]) begin
          mem[idx] = req[31:0];
          rdata    = req[31:0];
        end else begin
          rdata = mem[idx];
          if (mode == MODE_CORRUPT && idx == 2) rdata[0] = ~rdata[0];
        end
        lat = (mode == MODE_RANDOM) ? int'($urandom_range(1, 8)) : 1;
        pendRsp.push_back({4'hF, req[47:32], rdata});
        pendTime.push_back(cyc + lat - 1);
        pendWr.push_back(req[69]);
        modelOut++;
        if (modelOut > peakOut) peakOut = modelOut;
      end
    end
    #1;
    put_ready = (mode == MODE_RANDOM) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pendRsp.size() > 0 && pendTime[0] <= cyc && mode != MODE_NOGET &&
        (mode != MODE_RANDOM || $urandom_range(0, 2) != 0)) begin
      get_ready    = 1'b1;
      get_response = pendRsp[0];
    end else if (mode == MODE_SPURIOUS && writesPopped == NREQ && !spurDone) begin
      get_ready    = 1'b1;
      get_response = '0;
      spurDone     = 1'b1;
    end else begin
      get_ready    = 1'b0;
      get_response = '0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [69:0] observed, input logic [69:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic doReset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    checkOutput("wait_done", done, 1'b1);
  endtask

  initial begin
    int cycles;
    int waited;
    RST   = 1'b1;
    start = 1'b0;
    tick();
    tick();
    checkOutput("rst_put_valid", put_valid, 1'b0);
    checkOutput("rst_put_request", put_request, '0);
    checkOutput("rst_get_valid", get_valid, 1'b0);
    checkOutput("rst_status", {busy, done, pass, timeout}, 4'b0000);
    checkOutput("rst_err_count", err_count, 16'd0);
    RST = 1'b0;
    tick();

    $display("[TB] ideal echo run");
    mode = MODE_IDEAL;
    applyStimulus();
    checkOutput("start_busy", busy, 1'b1);
    checkOutput("start_put_valid", put_valid, 1'b1);
    checkOutput("req0", put_request, {1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0000_ACE1});
    tick();
    checkOutput("req1", put_request, {1'b1, 1'b0, 4'hF, 32'h0000_1004, 32'h8020_5673});
    tick();
    checkOutput("req2", put_request, {1'b1, 1'b0, 4'hF, 32'h0000_1008, 32'hC030_2B3A});
    tick();
    checkOutput("req3", put_request, {1'b1, 1'b0, 4'hF, 32'h0000_100C, 32'h6018_159D});
    waitDone(200, cycles);
    checkOutput("ideal_pass", pass, 1'b1);
    checkOutput("ideal_err", err_count, 16'd0);
    checkOutput("ideal_idle_flags", {busy, timeout, put_valid, get_valid}, 4'b0000);

    $display("[TB] corrupted read data run");
    mode = MODE_CORRUPT;
    applyStimulus();
    checkOutput("restart_done_falls", done, 1'b0);
    checkOutput("restart_busy", busy, 1'b1);
    waitDone(200, cycles);
    checkOutput("corrupt_pass", pass, 1'b0);
    checkOutput("corrupt_err", err_count, 16'd1);
    checkOutput("corrupt_timeout", timeout, 1'b0);

    $display("[TB] random backpressure run");
    mode = MODE_RANDOM;
    doReset();
    applyStimulus();
    waitDone(2000, cycles);
    checkOutput("random_pass", pass, 1'b1);
    checkOutput("random_err", err_count, 16'd0);
    checkOutput("random_peak_outstanding_ok", peakOut <= MAXO, 1'b1);
    checkOutput("random_request_stable", stabErr, 0);

    $display("[TB] stalled responder run");
    mode = MODE_NOGET;
    doReset();
    applyStimulus();
    waitDone(TMO + 50, cycles);
    checkOutput("stall_timeout", timeout, 1'b1);
    checkOutput("stall_pass", pass, 1'b0);
    checkOutput("stall_latency_ok", (cycles >= TMO) && (cycles <= TMO + MAXO + 4), 1'b1);

    $display("[TB] reset during read run");
    mode = MODE_IDEAL;
    doReset();
    applyStimulus();
    waited = 0;
    while (!(put_valid === 1'b1 && put_request[69] === 1'b0) && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput("reached_read_phase", put_request[69], 1'b0);
    RST = 1'b1;
    tick();
    checkOutput("midrst_put", {put_valid, put_request}, '0);
    checkOutput("midrst_status", {get_valid, busy, done, pass, timeout}, 5'b00000);
    checkOutput("midrst_err", err_count, 16'd0);
    RST = 1'b0;
    tick();
    applyStimulus();
    waitDone(200, cycles);
    checkOutput("after_rst_pass", pass, 1'b1);

    $display("[TB] spurious get in drain run");
    mode = MODE_SPURIOUS;
    doReset();
    applyStimulus();
    waitDone(200, cycles);
    checkOutput("spurious_err", err_count, 16'd1);
    checkOutput("spurious_pass", pass, 1'b0);
    checkOutput("spurious_no_timeout", timeout, 1'b0);
    checkOutput("spurious_injected", spurDone, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
